// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full-adder cell LSB-first.
// adder: 1-bit full-adder cell.
module adder (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic             sbit, cbit;
    logic [WIDTH-1:0] sr_next;
    adder u_adder (.s(sbit), .cout(cbit), .a(sa_q[0]), .b(sb_q[0]), .cin(c_q));
    // shift form avoids a zero-width slice when WIDTH is 1
    assign sr_next = (sr_q >> 1) | (WIDTH'(sbit) << (WIDTH - 1));
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == RUN) begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sr_d  = sr_next;
            c_d   = cbit;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                sum_d   = sr_next;
                cout_d  = cbit;
                state_d = DONE;
            end
        end else if (start) begin
            sa_d    = a;
            sb_d    = b;
            c_d     = cin;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial multi-bit adder sequencer built around the team's 1-bit full-adder cell `adder` (ports s, cout, a, b, cin). Latches two WIDTH-bit operands and a carry-in on a start request. Feeds them LSB-first through one `adder` instance, one bit per clock, with the carry held in a flip-flop between bits. Presents the registered WIDTH-bit sum and final carry-out with a one-cycle done pulse. It sits directly around the full-adder cell: it produces the cell's inputs and consumes its sum and carry outputs.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 1..32
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when the block is not busy
- a  input  WIDTH  operand A; sampled on the accepting edge only
- b  input  WIDTH  operand B; sampled on the accepting edge only
- cin  input  1  carry-in; sampled on the accepting edge only
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse: sum/cout just became valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out of bit WIDTH-1, held with sum

## Operation
- Internal state:
  - shift registers sa, sb (WIDTH each)
  - result shift register sr (WIDTH)
  - carry flip-flop c
  - bit counter cnt, width $clog2(WIDTH+1)
  - FSM states IDLE, RUN, DONE
- Exactly one `adder` instance. Inputs: sa[0], sb[0], c. Outputs: sbit, cbit.
- IDLE:
  - if start=1: load sa=a, sb=b, c=cin, cnt=0, and go to RUN
  - otherwise stay in IDLE
- RUN, every edge:
  - sa and sb shift right one bit; vacated MSB is 0
  - sr shifts right with sbit entering at MSB
  - c takes cbit
  - cnt increments
  - on the edge where cnt reaches WIDTH-1: load sum with the final sr value (including this edge's sbit), load cout with cbit, go to DONE
- DONE, one cycle only:
  - if start=1: accept new operands exactly as in IDLE, go to RUN
  - otherwise go to IDLE
- start in RUN is ignored; it is not queued.
- Changes on a/b/cin during RUN do not affect the result.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); cannot overflow.
- WIDTH=1: RUN lasts one edge.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - busy=0, done=0, sum=0, cout=0
  - state IDLE
  - sa, sb, sr, c, cnt all 0
- Reset asserted mid-RUN aborts the operation. No done pulse is generated and sum/cout read 0.
- Edge E0 is the edge where start is accepted.
  - busy=1 from E0 to E(WIDTH)
  - RUN processes one bit per edge, E1..E(WIDTH)
  - sum, cout update at E(WIDTH)
  - done=1 from E(WIDTH) to E(WIDTH+1)
  - busy=0 while done=1
- Throughput: with start held high, a new operation is accepted at every done cycle. Spacing is WIDTH+1 edges per result, with busy low only during the done cycles.
- sum/cout are stable throughout RUN; they still show the previous result.
- busy and done are never high at the same time.

## Test plan
- Reset, then run an addition:
  - stimulus: WIDTH=8, rst_n pulse, then a=8'h5A, b=8'h25, cin=0, start for one cycle
  - required: sum=8'h7F, cout=0; done high only at E8→E9; busy high E0→E8
- Carry propagation:
  - stimulus: a=8'hFF, b=8'h01, cin=0
  - required: sum=8'h00, cout=1
  - stimulus: a=8'hFF, b=8'hFF, cin=1
  - required: sum=8'hFF, cout=1
- start ignored during RUN, operands frozen:
  - stimulus: a=8'h10, b=8'h20, cin=0, accepted; at E3 drive start=1, a=8'hFF
  - required: result 8'h30 with cout=0; only one done pulse; no second operation starts
- Reset mid-operation:
  - stimulus: accept a=8'h0F, b=8'h01, cin=0; drop rst_n between E4 and E5
  - required: busy, done, sum and cout go to 0 immediately, with no clock edge needed
  - then: a fresh start produces 8'h10 at E8
- Back-to-back:
  - stimulus: hold start=1 with a=8'h03, b=8'h04, cin=1
  - required: done pulses at E8, E17, E26, each with sum=8'h08, cout=0
- WIDTH=1 exhaustive:
  - stimulus: all 8 combinations of a, b, cin
  - required: {cout,sum} = a+b+cin for each (e.g. 1,1,1 → cout=1, sum=1); done at E1
